// File: rtl/victim_writeback.sv
// Writeback engine: captures an evicted 256-bit cache line into a local buffer
// and streams it to memory as eight 32-bit beats over a valid/ready handshake.
module victim_writeback #(
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wbReq,
  input  logic [1:0]       wbWay,
  input  logic [2:0]       wbIndex,
  input  logic [TAG_W-1:0] wbTag,
  output logic             wbBusy,
  output logic             wbDone,
  output logic [1:0]       cWay,
  output logic [2:0]       cIndex,
  output logic             cRead,
  input  logic [255:0]     selBlock,
  output logic             memValid,
  input  logic             memReady,
  output logic [TAG_W+7:0] memAddr,
  output logic [31:0]      memData,
  output logic             memLast
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cWay_q, cWay_d;
  logic [2:0]         cIndex_q, cIndex_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2:0]         beat_q, beat_d;
  logic [255:0]       buffer_q, buffer_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cWay_q   <= '0;
      cIndex_q <= '0;
      tag_q    <= '0;
      beat_q   <= '0;
      buffer_q <= '0;
    end else begin
      state_q  <= state_d;
      cWay_q   <= cWay_d;
      cIndex_q <= cIndex_d;
      tag_q    <= tag_d;
      beat_q   <= beat_d;
      buffer_q <= buffer_d;
    end
  end

  // The buffer is the sole data source once CAPTURE ends, so later array
  // writes or selBlock changes cannot corrupt a line already in flight.
  always_comb begin
    state_d  = state_q;
    cWay_d   = cWay_q;
    cIndex_d = cIndex_q;
    tag_d    = tag_q;
    beat_d   = beat_q;
    buffer_d = buffer_q;
    case (state_q)
      IDLE: begin
        if (wbReq) begin
          cWay_d   = wbWay;
          cIndex_d = wbIndex;
          tag_d    = wbTag;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        buffer_d = selBlock;
        beat_d   = 3'd0;
        state_d  = SEND;
      end
      SEND: begin
        if (memReady) begin
          if (beat_q == 3'd7) state_d = DONE;
          else                beat_d  = beat_q + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wbBusy   = (state_q != IDLE);
  assign wbDone   = (state_q == DONE);
  assign cRead    = (state_q == CAPTURE);
  assign memValid = (state_q == SEND);
  assign memLast  = (state_q == SEND) && (beat_q == 3'd7);
  assign cWay     = cWay_q;
  assign cIndex   = cIndex_q;
  assign memData  = buffer_q[{beat_q, 5'b00000} +: 32];
  assign memAddr  = {tag_q, cIndex_q, beat_q, 2'b00};

endmodule

// File: tb/tb_victim_writeback.sv
// Self-checking bench for victim_writeback: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_victim_writeback;
  localparam int TAG_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wbReq = 1'b0;
  logic [1:0]       wbWay = '0;
  logic [2:0]       wbIndex = '0;
  logic [TAG_W-1:0] wbTag = '0;
  logic             wbBusy, wbDone, cRead, memValid, memLast;
  logic [1:0]       cWay;
  logic [2:0]       cIndex;
  logic [255:0]     selBlock = '0;
  logic             memReady = 1'b1;
  logic [TAG_W+7:0] memAddr;
  logic [31:0]      memData;

  int total = 0;
  int bad = 0;
  bit checkEn = 0;
  int cyc = 0;
  int doneCount = 0;
  logic [31:0]      beatQ[$];
  logic [TAG_W+7:0] addrQ[$];

  always #5 clk = ~clk;

  victim_writeback #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .wbReq(wbReq), .wbWay(wbWay), .wbIndex(wbIndex),
    .wbTag(wbTag), .wbBusy(wbBusy), .wbDone(wbDone), .cWay(cWay), .cIndex(cIndex),
    .cRead(cRead), .selBlock(selBlock), .memValid(memValid), .memReady(memReady),
    .memAddr(memAddr), .memData(memData), .memLast(memLast)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a line is "active" from acceptance until its done cycle;
  // the first active cycle is the capture, then beats go out one per handshake.
  bit               mActive = 0, mCapture = 0;
  int               mBeats = 0;
  logic [1:0]       mWay = '0;
  logic [2:0]       mIndex = '0;
  logic [TAG_W-1:0] mTag = '0;
  logic [255:0]     mLine = '0;

  always @(posedge clk) begin
    if (!reset) begin
      mActive = 0; mCapture = 0; mBeats = 0;
      mWay = '0; mIndex = '0; mTag = '0; mLine = '0;
    end else if (!mActive) begin
      if (wbReq) begin
        mActive = 1; mCapture = 1; mBeats = 0;
        mWay = wbWay; mIndex = wbIndex; mTag = wbTag;
      end
    end else if (mCapture) begin
      mLine = selBlock;
      mCapture = 0;
    end else if (mBeats < 8) begin
      if (memReady) mBeats++;
    end else begin
      mActive = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (reset && memValid && memReady) begin
      beatQ.push_back(memData);
      addrQ.push_back(memAddr);
    end
    if (reset && wbDone) doneCount++;
  end

  always @(negedge clk) begin
    bit expSend;
    if (checkEn) begin
      expSend = mActive && !mCapture && (mBeats < 8);
      checkOutput("wbBusy", wbBusy, mActive);
      checkOutput("wbDone", wbDone, mActive && (mBeats == 8));
      checkOutput("cRead", cRead, mActive && mCapture);
      checkOutput("memValid", memValid, expSend);
      checkOutput("cWay", cWay, mWay);
      checkOutput("cIndex", cIndex, mIndex);
      if (expSend) begin
        checkOutput("memLast", memLast, mBeats == 7);
        checkOutput("memData", memData, mLine[32*mBeats +: 32]);
        checkOutput("memAddr", memAddr, {mTag, mIndex, mBeats[2:0], 2'b00});
      end
    end
  end

  task automatic setWords(input logic [31:0] baseVal);
    for (int i = 0; i < 8; i++) selBlock[32*i +: 32] = baseVal + i;
  endtask

  task automatic applyStimulus(input logic [1:0] w, input logic [2:0] ix, input logic [TAG_W-1:0] t);
    wbReq = 1'b1; wbWay = w; wbIndex = ix; wbTag = t;
    @(posedge clk); #1;
    wbReq = 1'b0;
  endtask

  // Runs one line from cycle 1; mode 0 always ready, 1 stalls beats 0/3/7 for
  // two cycles each, 2 random ready. resetAfter>=0 aborts once that many beats went.
  task automatic runLine(input int mode, input bit isolate, input bit busyReq,
                         input int resetAfter, input int base, output int doneCyc);
    int n, b, stallBeat, stallN, doneBefore;
    bit seen;
    n = 1; seen = 0; doneCyc = -1; stallBeat = -1; stallN = 0;
    doneBefore = doneCount;
    while (n < 80 && !seen) begin
      @(negedge clk);
      if (wbDone) begin seen = 1; doneCyc = n; end
      #1;
      b = beatQ.size() - base;
      if (isolate && n >= 2) selBlock = '1;
      if (busyReq) begin
        wbReq = (n == 4); wbWay = 2'd1; wbIndex = 3'd3;
      end
      if (resetAfter >= 0 && memValid && b == resetAfter) begin
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstMemValid", memValid, 0);
        checkOutput("rstBusy", wbBusy, 0);
        checkOutput("rstDone", wbDone, 0);
        checkOutput("rstMemAddr", memAddr, 0);
        #1 reset = 1'b1;
        repeat (12) @(posedge clk);
        checkOutput("rstNoDone", doneCount, doneBefore);
        @(negedge clk); #1;
        return;
      end
      case (mode)
        1: begin
          if (b != stallBeat) begin stallBeat = b; stallN = 0; end
          if (memValid && (b == 0 || b == 3 || b == 7) && stallN < 2) begin
            memReady = 1'b0; stallN++;
          end else memReady = 1'b1;
        end
        2: memReady = ($urandom_range(0, 3) != 0);
        default: memReady = 1'b1;
      endcase
      n++;
    end
    wbReq = 1'b0;
    memReady = 1'b1;
    if (!seen) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    @(negedge clk);
    while (wbBusy && k < 60) begin @(negedge clk); k++; end
    if (wbBusy) checkOutput("idleTimeout", 0, 1);
    #1;
  endtask

  task automatic checkBeats(input string name, input int base, input logic [31:0] dBase,
                            input logic [TAG_W+7:0] aBase, input bit checkAddr);
    checkOutput({name, "Count"}, beatQ.size() - base, 8);
    for (int i = 0; i < 8 && base + i < beatQ.size(); i++) begin
      checkOutput({name, "Data"}, beatQ[base+i], dBase + i);
      if (checkAddr) checkOutput({name, "Addr"}, addrQ[base+i], aBase + 4*i);
    end
  endtask

  initial begin
    int d, base, dc;
    int caps[$];
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", wbBusy, 0);
    checkOutput("resetValid", memValid, 0);
    checkOutput("resetData", memData, 0);
    checkOutput("resetAddr", memAddr, 0);
    checkOutput("resetWay", cWay, 0);
    checkEn = 1;
    #1 reset = 1'b1;
    @(negedge clk); #1;

    $display("[TB] basic eviction");
    setWords(32'd0);
    base = beatQ.size();
    applyStimulus(2'd2, 3'd5, 24'hABCDEF);
    checkOutput("basicWay", cWay, 2);
    checkOutput("basicIndex", cIndex, 5);
    checkOutput("basicRead", cRead, 1);
    runLine(0, 0, 0, -1, base, d);
    checkOutput("basicDoneCyc", d, 10);
    checkBeats("basic", base, 32'd0, 32'hABCDEFA0, 1);
    @(negedge clk); #1;

    $display("[TB] backpressure");
    setWords(32'h10);
    base = beatQ.size();
    applyStimulus(2'd1, 3'd6, 24'h123456);
    runLine(1, 0, 0, -1, base, d);
    checkOutput("bpDoneCyc", d, 16);
    checkBeats("bp", base, 32'h10, 32'h123456C0, 1);
    @(negedge clk); #1;

    $display("[TB] buffer isolation");
    setWords(32'd0);
    base = beatQ.size();
    applyStimulus(2'd3, 3'd1, 24'h00FF00);
    runLine(0, 1, 0, -1, base, d);
    checkBeats("iso", base, 32'd0, 32'h00FF0020, 1);
    @(negedge clk); #1;

    $display("[TB] request while busy");
    setWords(32'h40);
    base = beatQ.size();
    dc = doneCount;
    applyStimulus(2'd2, 3'd5, 24'h777777);
    runLine(0, 0, 1, -1, base, d);
    checkOutput("busyWay", cWay, 2);
    checkOutput("busyIndex", cIndex, 5);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("busyOneDone", doneCount - dc, 1);
    checkOutput("busyIdle", wbBusy, 0);
    #1;

    $display("[TB] reset mid-line");
    setWords(32'h100);
    base = beatQ.size();
    applyStimulus(2'd0, 3'd2, 24'h0A0A0A);
    runLine(0, 0, 0, 5, base, d);
    checkOutput("rstPartial", beatQ.size() - base, 5);
    setWords(32'h200);
    base = beatQ.size();
    applyStimulus(2'd1, 3'd2, 24'h0B0B0B);
    runLine(0, 0, 0, -1, base, d);
    checkOutput("rstFreshDoneCyc", d, 10);
    checkBeats("rstFresh", base, 32'h200, 32'h0B0B0B40, 1);
    @(negedge clk); #1;

    $display("[TB] back-to-back");
    setWords(32'h300);
    wbReq = 1'b1; wbWay = 2'd3; wbIndex = 3'd7; wbTag = 24'h555555;
    memReady = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (cRead) caps.push_back(cyc);
    end
    #1 wbReq = 1'b0;
    checkOutput("b2bCaptures", caps.size() >= 3, 1);
    for (int k = 1; k < caps.size(); k++) checkOutput("b2bSpacing", caps[k] - caps[k-1], 11);
    waitIdle();

    $display("[TB] randomized lines");
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 8; i++) selBlock[32*i +: 32] = $urandom;
      base = beatQ.size();
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), TAG_W'($urandom));
      runLine(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, base, d);
      checkOutput("rndCount", beatQ.size() - base, 8);
      @(negedge clk); #1;
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
